// File: rtl/cim_xbar_arbiter.sv
// Round-robin arbiter that time-shares one CIM crossbar between num_layers layers.
// Optional LOAD watchdog is built only when CIM_ARB_TIMEOUT_EN is defined.
module cim_xbar_arbiter #(
   parameter int num_layers     = 4,
   parameter int xbar_size      = 128,
   parameter int datatype_size  = 8,
   parameter int v_cim_tiles    = 1,
   parameter int cim_latency    = 4,
   parameter int timeout_cycles = 1024
) (
   input  logic                                                     clk,
   input  logic                                                     rst,
   input  logic [num_layers-1:0]                                    i_req,
   input  logic [num_layers-1:0]                                    i_wr_en,
   input  logic [num_layers-1:0]                                    i_last,
   input  logic [num_layers-1:0][$clog2(xbar_size)-1:0]             i_wr_addr,
   input  logic [num_layers-1:0][v_cim_tiles-1:0][datatype_size-1:0] i_wr_data,
   output logic [num_layers-1:0]                                    o_cim_busy,
   output logic [num_layers-1:0]                                    o_func_start,
   output logic [num_layers-1:0]                                    o_grant,
   output logic                                                     o_xbar_we,
   output logic [$clog2(xbar_size)-1:0]                             o_xbar_wr_addr,
   output logic [v_cim_tiles-1:0][datatype_size-1:0]                o_xbar_data,
   output logic                                                     o_xbar_compute,
   output logic                                                     o_timeout
);

   localparam int idx_w = (num_layers > 1) ? $clog2(num_layers) : 1;
   localparam int cnt_w = (cim_latency > 1) ? $clog2(cim_latency) : 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      COMPUTE,
      DONE
   } state_t;

   state_t           state;
   logic [idx_w-1:0] ptr;
   logic [idx_w-1:0] gidx;
   logic [cnt_w-1:0] count;
   logic             pick_valid;
   logic [idx_w-1:0] pick_idx;
   logic [idx_w-1:0] cand_idx;
   int               cand;

`ifdef CIM_ARB_TIMEOUT_EN
   localparam int wd_w = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
   logic [wd_w-1:0] wd_cnt;
`endif

   // Scan downwards so the last hit is the first requester at or after the pointer.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int i = num_layers - 1; i >= 0; i--) begin
         cand = int'(ptr) + i;
         if (cand >= num_layers) begin
            cand = cand - num_layers;
         end
         cand_idx = idx_w'(cand);
         if (i_req[cand_idx]) begin
            pick_valid = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ptr          <= '0;
         gidx         <= '0;
         count        <= '0;
         o_grant      <= '0;
         o_func_start <= '0;
`ifdef CIM_ARB_TIMEOUT_EN
         wd_cnt       <= '0;
         o_timeout    <= 1'b0;
`endif
      end else begin
         o_func_start <= '0;
`ifdef CIM_ARB_TIMEOUT_EN
         o_timeout    <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  gidx    <= pick_idx;
                  o_grant <= num_layers'(1) << pick_idx;
                  ptr     <= (pick_idx == idx_w'(num_layers - 1)) ? '0 : pick_idx + idx_w'(1);
                  state   <= LOAD;
`ifdef CIM_ARB_TIMEOUT_EN
                  wd_cnt  <= '0;
`endif
               end
            end
            LOAD: begin
               // A final write wins over a request drop seen in the same cycle.
               if (i_wr_en[gidx] && i_last[gidx]) begin
                  count <= cnt_w'(cim_latency - 1);
                  state <= COMPUTE;
               end else if (!i_req[gidx]) begin
                  o_grant <= '0;
                  state   <= IDLE;
               end
`ifdef CIM_ARB_TIMEOUT_EN
               else if (i_wr_en[gidx]) begin
                  wd_cnt <= '0;
               end else if (wd_cnt == wd_w'(timeout_cycles - 1)) begin
                  o_grant   <= '0;
                  o_timeout <= 1'b1;
                  state     <= IDLE;
               end else begin
                  wd_cnt <= wd_cnt + wd_w'(1);
               end
`endif
            end
            COMPUTE: begin
               if (count == '0) begin
                  o_func_start <= o_grant;
                  state        <= DONE;
               end else begin
                  count <= count - cnt_w'(1);
               end
            end
            DONE: begin
               o_grant <= '0;
               state   <= IDLE;
            end
            default: begin
               o_grant <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

`ifndef CIM_ARB_TIMEOUT_EN
   // Watchdog absent: the timeout output is a constant zero whatever timeout_cycles holds.
   assign o_timeout = 1'b0 & (timeout_cycles == 0);
`endif

   always_comb begin
      o_cim_busy     = '1;
      o_xbar_we      = 1'b0;
      o_xbar_wr_addr = '0;
      o_xbar_data    = '0;
      o_xbar_compute = (state == COMPUTE);
      if (state == LOAD) begin
         o_cim_busy     = ~o_grant;
         o_xbar_we      = i_wr_en[gidx];
         o_xbar_wr_addr = i_wr_addr[gidx];
         o_xbar_data    = i_wr_data[gidx];
      end
   end

endmodule

// File: tb/tb_cim_xbar_arbiter.sv
// Randomized bench for cim_xbar_arbiter against a transaction-level round-robin model.
// Exercises the LOAD watchdog when CIM_ARB_TIMEOUT_EN is defined.
module tb_cim_xbar_arbiter;

   localparam int N   = 4;
   localparam int XS  = 128;
   localparam int DT  = 8;
   localparam int VT  = 1;
   localparam int LAT = 4;
   localparam int TO  = 8;
   localparam int AW  = $clog2(XS);
   localparam int IW  = $clog2(N);
   localparam int DW  = VT * DT;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0]                  i_req;
   logic [N-1:0]                  i_wr_en;
   logic [N-1:0]                  i_last;
   logic [N-1:0][AW-1:0]          i_wr_addr;
   logic [N-1:0][VT-1:0][DT-1:0]  i_wr_data;
   logic [N-1:0]                  o_cim_busy;
   logic [N-1:0]                  o_func_start;
   logic [N-1:0]                  o_grant;
   logic                          o_xbar_we;
   logic [AW-1:0]                 o_xbar_wr_addr;
   logic [VT-1:0][DT-1:0]         o_xbar_data;
   logic                          o_xbar_compute;
   logic                          o_timeout;

   int checks = 0;
   int errors = 0;
   int mptr   = 0;

   always #5 clk = ~clk;

   cim_xbar_arbiter #(
      .num_layers    (N),
      .xbar_size     (XS),
      .datatype_size (DT),
      .v_cim_tiles   (VT),
      .cim_latency   (LAT),
      .timeout_cycles(TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_req         (i_req),
      .i_wr_en       (i_wr_en),
      .i_last        (i_last),
      .i_wr_addr     (i_wr_addr),
      .i_wr_data     (i_wr_data),
      .o_cim_busy    (o_cim_busy),
      .o_func_start  (o_func_start),
      .o_grant       (o_grant),
      .o_xbar_we     (o_xbar_we),
      .o_xbar_wr_addr(o_xbar_wr_addr),
      .o_xbar_data   (o_xbar_data),
      .o_xbar_compute(o_xbar_compute),
      .o_timeout     (o_timeout)
   );

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1; i_req = '0; i_wr_en = '0; i_last = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      mptr = 0;
   endtask

   // One full transaction: idle cycle, load with random gaps and foreign writes, compute, done.
   task automatic serve(input logic [N-1:0] mask, input int nwr, input bit exp_to,
                        input int noise_layer, input int noise_addr);
      logic [IW-1:0] w, nl;
      logic [N-1:0]  g;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            left, gaps;
      bit            wr;
      w = '0;
      for (int i = N - 1; i >= 0; i--)
         if (mask[IW'((mptr + i) % N)]) w = IW'((mptr + i) % N);
      g = N'(1) << w;

      @(negedge clk);
      i_req = mask; i_wr_en = '0; i_last = N'($urandom);
      #1;
      checks++;
      if (o_grant !== '0 || o_func_start !== '0) begin
         errors++; $display("[TB] FAIL idle_grant: grant=%b func_start=%b, expected 0000/0000", o_grant, o_func_start);
      end
      checks++;
      if (o_timeout !== exp_to) begin
         errors++; $display("[TB] FAIL idle_timeout: got %b expected %b", o_timeout, exp_to);
      end
      checks++;
      if (o_xbar_we !== 1'b0 || o_cim_busy !== '1 || o_xbar_compute !== 1'b0) begin
         errors++; $display("[TB] FAIL idle_ctl: we=%b busy=%b compute=%b, expected 0/1111/0", o_xbar_we, o_cim_busy, o_xbar_compute);
      end
      mptr = (int'(w) + 1) % N;

      left = nwr; gaps = 0;
      while (left > 0) begin
         @(negedge clk);
         wr = (gaps >= 2) || ($urandom_range(0, 2) != 0);
         a  = AW'($urandom_range(0, XS - 1));
         if (noise_addr >= 0 && a == AW'(noise_addr)) a = a + AW'(1);
         d  = DW'($urandom);
         i_wr_en = '0; i_last = N'($urandom);
         i_wr_addr[w] = a; i_wr_data[w] = d;
         if (wr) begin
            i_wr_en[w] = 1'b1; i_last[w] = (left == 1);
         end
         nl = (noise_layer >= 0) ? IW'(noise_layer) : IW'((int'(w) + 1 + $urandom_range(0, N - 2)) % N);
         if (noise_layer >= 0 || $urandom_range(0, 1) == 1) begin
            i_wr_en[nl]   = 1'b1;
            i_wr_addr[nl] = (noise_addr >= 0) ? AW'(noise_addr) : AW'($urandom_range(0, XS - 1));
            i_wr_data[nl] = DW'($urandom);
         end
         #1;
         checks++;
         if (o_grant !== g || o_cim_busy !== ~g) begin
            errors++; $display("[TB] FAIL load_grant: grant=%b busy=%b, expected %b/%b", o_grant, o_cim_busy, g, ~g);
         end
         checks++;
         if (o_xbar_we !== wr) begin
            errors++; $display("[TB] FAIL load_we: got %b expected %b", o_xbar_we, wr);
         end
         checks++;
         if (o_xbar_wr_addr !== a || o_xbar_data !== d) begin
            errors++; $display("[TB] FAIL load_route: addr=%0d data=%h, expected %0d/%h", o_xbar_wr_addr, o_xbar_data, a, d);
         end
         if (wr) left--;
         gaps = wr ? 0 : gaps + 1;
      end

      for (int k = 0; k < LAT; k++) begin
         @(negedge clk);
         i_wr_en = N'($urandom); i_last = N'($urandom);
         #1;
         checks++;
         if (o_xbar_compute !== 1'b1 || o_cim_busy !== '1) begin
            errors++; $display("[TB] FAIL compute: cycle %0d compute=%b busy=%b, expected 1/1111", k, o_xbar_compute, o_cim_busy);
         end
         checks++;
         if (o_grant !== g || o_func_start !== '0 || o_xbar_we !== 1'b0 || o_xbar_wr_addr !== '0) begin
            errors++; $display("[TB] FAIL compute_ctl: grant=%b fs=%b we=%b addr=%0d, expected %b/0000/0/0", o_grant, o_func_start, o_xbar_we, o_xbar_wr_addr, g);
         end
      end

      @(negedge clk);
      i_wr_en = '0; i_last = '0;
      #1;
      checks++;
      if (o_func_start !== g || o_grant !== g || o_xbar_compute !== 1'b0) begin
         errors++; $display("[TB] FAIL done: fs=%b grant=%b compute=%b, expected %b/%b/0", o_func_start, o_grant, o_xbar_compute, g, g);
      end
   endtask

   task automatic test_reset;
      $display("[TB] test_reset");
      @(negedge clk);
      rst = 1'b1; i_req = '1; i_wr_en = '1; i_last = '1;
      i_wr_addr = {N{AW'(7)}};
      @(negedge clk);
      #1;
      checks++;
      if (o_grant !== '0 || o_func_start !== '0 || o_cim_busy !== '1) begin
         errors++; $display("[TB] FAIL reset_arb: grant=%b fs=%b busy=%b, expected 0000/0000/1111", o_grant, o_func_start, o_cim_busy);
      end
      checks++;
      if (o_xbar_we !== 1'b0 || o_xbar_wr_addr !== '0 || o_xbar_data !== '0 || o_xbar_compute !== 1'b0 || o_timeout !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_xbar: we=%b addr=%0d data=%h compute=%b to=%b, expected all 0", o_xbar_we, o_xbar_wr_addr, o_xbar_data, o_xbar_compute, o_timeout);
      end
      @(negedge clk);
      rst = 1'b0; i_req = '0; i_wr_en = '0; i_last = '0;
      mptr = 0;
   endtask

   task automatic test_single;
      $display("[TB] test_single");
      do_reset();
      serve(4'b0001, 3, 1'b0, -1, -1);
   endtask

   task automatic test_contention;
      $display("[TB] test_contention");
      do_reset();
      repeat (5) serve(4'b1111, 1, 1'b0, -1, -1);
      repeat (8) serve(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(1, 4), 1'b0, -1, -1);
   endtask

   task automatic test_isolation;
      $display("[TB] test_isolation");
      do_reset();
      serve(4'b0001, 4, 1'b0, 2, 5);
   endtask

   task automatic test_abort;
      $display("[TB] test_abort");
      do_reset();
      @(negedge clk);
      i_req = 4'b0110; i_wr_en = '0; i_last = '0;
      #1;
      mptr = 2;
      repeat (2) begin
         @(negedge clk);
         i_wr_en = 4'b0010; i_last = '0;
         #1;
         checks++;
         if (o_grant !== 4'b0010) begin
            errors++; $display("[TB] FAIL abort_grant: got %b expected 0010", o_grant);
         end
      end
      @(negedge clk);
      i_req = 4'b0100; i_wr_en = '0; i_last = '0;
      #1;
      checks++;
      if (o_grant !== 4'b0010 || o_func_start !== '0) begin
         errors++; $display("[TB] FAIL abort_drop: grant=%b fs=%b, expected 0010/0000", o_grant, o_func_start);
      end
      serve(4'b0100, 2, 1'b0, -1, -1);
   endtask

   task automatic test_reset_mid;
      $display("[TB] test_reset_mid");
      do_reset();
      @(negedge clk);
      i_req = 4'b0001; i_wr_en = '0; i_last = '0;
      @(negedge clk);
      i_wr_en = 4'b0001; i_last = 4'b0001;
      @(negedge clk);
      i_wr_en = '0; i_last = '0;
      #1;
      checks++;
      if (o_xbar_compute !== 1'b1) begin
         errors++; $display("[TB] FAIL mid_compute: got %b expected 1", o_xbar_compute);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; i_req = '0;
      #1;
      checks++;
      if (o_grant !== '0 || o_func_start !== '0 || o_xbar_compute !== 1'b0 || o_cim_busy !== '1 || o_xbar_we !== 1'b0) begin
         errors++; $display("[TB] FAIL mid_reset: grant=%b fs=%b compute=%b busy=%b we=%b, expected 0000/0000/0/1111/0", o_grant, o_func_start, o_xbar_compute, o_cim_busy, o_xbar_we);
      end
      repeat (4) begin
         @(negedge clk);
         #1;
         checks++;
         if (o_func_start !== '0 || o_grant !== '0) begin
            errors++; $display("[TB] FAIL mid_after: fs=%b grant=%b, expected 0000/0000", o_func_start, o_grant);
         end
      end
      mptr = 0;
      serve(4'b1111, 1, 1'b0, -1, -1);
   endtask

   task automatic test_timeout;
      $display("[TB] test_timeout");
      do_reset();
      @(negedge clk);
      i_req = 4'b0011; i_wr_en = '0; i_last = '0;
`ifdef CIM_ARB_TIMEOUT_EN
      for (int k = 0; k < TO; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (o_grant !== 4'b0001 || o_timeout !== 1'b0) begin
            errors++; $display("[TB] FAIL to_wait: cycle %0d grant=%b to=%b, expected 0001/0", k, o_grant, o_timeout);
         end
      end
      mptr = 1;
      serve(4'b0011, 2, 1'b1, -1, -1);
`else
      repeat (3 * TO) begin
         @(negedge clk);
         #1;
         checks++;
         if (o_grant !== 4'b0001 || o_timeout !== 1'b0 || o_cim_busy !== 4'b1110) begin
            errors++; $display("[TB] FAIL to_hold: grant=%b to=%b busy=%b, expected 0001/0/1110", o_grant, o_timeout, o_cim_busy);
         end
      end
      do_reset();
`endif
   endtask

   initial begin
      rst = 1'b1; i_req = '0; i_wr_en = '0; i_last = '0;
      i_wr_addr = '0; i_wr_data = '0;
      test_reset();
      test_single();
      test_contention();
      test_isolation();
      test_abort();
      test_reset_mid();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
